// File: rtl/pulse_divider.sv
// Programmable-period strobe generator: one registered tick every active_p enabled cycles, periodic or one-shot.
// Latency: first tick is visible in the cycle after edge E0+P, where E0 is the start edge; enable low holds all state except load capture.
// Optional PULSE_DIVIDER_STRETCH_EN holds each tick high for PULSE_LEN enabled cycles.
module pulse_divider #(
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 5,
  parameter int TALLY_W        = 16
`ifdef PULSE_DIVIDER_STRETCH_EN
  , parameter int PULSE_LEN    = 1
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic               load,
  input  logic [WIDTH-1:0]   period,
  output logic               out_pulse,
  output logic [WIDTH-1:0]   cnt,
  output logic               busy,
  output logic [TALLY_W-1:0] tally
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   cnt_n;
  logic [WIDTH-1:0]   active_p, active_p_n;
  logic [WIDTH-1:0]   shadow_p, shadow_p_n;
  logic [WIDTH-1:0]   period_clamped;
  logic               pend, pend_n;
  logic               run_mode, run_mode_n;
  logic [TALLY_W-1:0] tally_n;
  logic               wrap;
  logic               tick;

  assign period_clamped = (period == '0) ? WIDTH'(1) : period;
  assign wrap           = (cnt == active_p - 1'b1);
  assign busy           = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      active_p <= WIDTH'(DEFAULT_PERIOD);
      shadow_p <= WIDTH'(DEFAULT_PERIOD);
      pend     <= 1'b0;
      run_mode <= 1'b0;
      tally    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      active_p <= active_p_n;
      shadow_p <= shadow_p_n;
      pend     <= pend_n;
      run_mode <= run_mode_n;
      tally    <= tally_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    active_p_n = active_p;
    shadow_p_n = shadow_p;
    pend_n     = pend;
    run_mode_n = run_mode;
    tally_n    = tally;
    tick       = 1'b0;
    case (state)
      IDLE: begin
        if (load) active_p_n = period_clamped;
        if (enable && start && !stop) begin
          state_n    = RUN;
          cnt_n      = '0;
          tally_n    = '0;
          run_mode_n = mode;
          if (pend) begin
            active_p_n = shadow_p;
            pend_n     = 1'b0;
          end
        end
      end
      RUN: begin
        if (load) begin
          shadow_p_n = period_clamped;
          pend_n     = 1'b1;
        end
        if (enable) begin
          if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            pend_n  = 1'b0;
          end else if (wrap) begin
            cnt_n   = '0;
            tick    = 1'b1;
            tally_n = tally + 1'b1;
            // A load on this same edge only lands in shadow_p; the old pending value applies now.
            if (pend) begin
              active_p_n = shadow_p;
              pend_n     = load;
            end
            if (run_mode) state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PULSE_DIVIDER_STRETCH_EN
  localparam int SW = $clog2(PULSE_LEN + 1);
  logic [SW-1:0] str_rem;

  // Stretch counts enabled cycles only; a fresh tick restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pulse <= 1'b0;
      str_rem   <= '0;
    end else if (tick) begin
      out_pulse <= 1'b1;
      str_rem   <= SW'(PULSE_LEN - 1);
    end else if (enable) begin
      out_pulse <= (str_rem != '0);
      if (str_rem != '0) str_rem <= str_rem - 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) out_pulse <= 1'b0;
    else       out_pulse <= tick;
  end
`endif

endmodule

// File: tb/tb_pulse_divider.sv
// Directed bench for pulse_divider in its default build (WIDTH=8, DEFAULT_PERIOD=5, TALLY_W=16).
module tb_pulse_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic        start;
  logic        stop;
  logic        load;
  logic [7:0]  period;
  logic        out_pulse;
  logic [7:0]  cnt;
  logic        busy;
  logic [15:0] tally;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  pulse_divider #(.WIDTH(8), .DEFAULT_PERIOD(5), .TALLY_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .period    (period),
    .out_pulse (out_pulse),
    .cnt       (cnt),
    .busy      (busy),
    .tally     (tally)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, so each step covers exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0; start = 1'b0;
    stop = 1'b0; load = 1'b0; period = 8'd0;
    step(); step();
    chk("rst_out_pulse", 32'(out_pulse), 32'd0);
    chk("rst_cnt",       32'(cnt),       32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_tally",     32'(tally),     32'd0);
    reset = 1'b0;

    // Periodic, default period 5
    start = 1'b1; step(); start = 1'b0;
    chk("p5_busy_start", 32'(busy), 32'd1);
    chk("p5_cnt_start",  32'(cnt),  32'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("p5_cnt_k%0d", k),   32'(cnt),       32'(k % 5));
      chk($sformatf("p5_pulse_k%0d", k), 32'(out_pulse), 32'(k % 5 == 0));
      chk($sformatf("p5_tally_k%0d", k), 32'(tally),     32'(k / 5));
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("p5_stop_busy",  32'(busy),      32'd0);
    chk("p5_stop_cnt",   32'(cnt),       32'd0);
    chk("p5_stop_pulse", 32'(out_pulse), 32'd0);
    chk("p5_stop_tally", 32'(tally),     32'd3);

    // start together with stop in IDLE: stop wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle_busy", 32'(busy), 32'd0);

    // One-shot, period 3 loaded in IDLE
    load = 1'b1; period = 8'd3; step(); load = 1'b0;
    mode = 1'b1; start = 1'b1; step(); start = 1'b0; mode = 1'b0;
    chk("os_busy_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 2; k++) begin
      step();
      chk($sformatf("os_pulse_k%0d", k), 32'(out_pulse), 32'd0);
      chk($sformatf("os_busy_k%0d", k),  32'(busy),      32'd1);
    end
    step();
    chk("os_pulse_k3", 32'(out_pulse), 32'd1);
    chk("os_busy_k3",  32'(busy),      32'd0);
    chk("os_tally_k3", 32'(tally),     32'd1);
    chk("os_cnt_k3",   32'(cnt),       32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_pulse) pulses++;
    end
    chk("os_no_more_pulses", 32'(pulses), 32'd0);
    chk("os_tally_after",    32'(tally),  32'd1);

    // Periodic P=4 with load of 2 on the wrap edge
    load = 1'b1; period = 8'd4; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("rl_cnt_k3", 32'(cnt), 32'd3);
    load = 1'b1; period = 8'd2; step(); load = 1'b0;
    chk("rl_pulse_k4", 32'(out_pulse), 32'd1);
    for (int k = 5; k <= 12; k++) begin
      step();
      chk($sformatf("rl_pulse_k%0d", k), 32'(out_pulse), 32'(k == 8 || k == 10 || k == 12));
      chk($sformatf("rl_cnt_k%0d", k),   32'(cnt),
          32'((k == 8 || k == 10 || k == 12) ? 0 : (k <= 7 ? k - 4 : 1)));
    end
    stop = 1'b1; step(); stop = 1'b0;

    // P=6 with enable held low at cnt=2
    load = 1'b1; period = 8'd6; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("en_cnt_before", 32'(cnt), 32'd2);
    enable = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("en_frozen_cnt_%0d", k), 32'(cnt), 32'd2);
      if (out_pulse) pulses++;
    end
    chk("en_frozen_no_pulse", 32'(pulses), 32'd0);
    chk("en_frozen_busy",     32'(busy),   32'd1);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("en_resume_pulse_k%0d", k), 32'(out_pulse), 32'(k == 4));
      chk($sformatf("en_resume_cnt_k%0d", k),   32'(cnt),       32'((k == 4) ? 0 : k + 2));
    end
    chk("en_tally", 32'(tally), 32'd1);

    // stop on the wrap edge: no pulse, no tally increment
    step(); step(); step(); step(); step();
    chk("sw_cnt_before", 32'(cnt), 32'd5);
    stop = 1'b1; step(); stop = 1'b0;
    chk("sw_pulse", 32'(out_pulse), 32'd0);
    chk("sw_cnt",   32'(cnt),       32'd0);
    chk("sw_busy",  32'(busy),      32'd0);
    chk("sw_tally", 32'(tally),     32'd1);

    // reset mid-run at cnt=3 restores default period 5
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("mr_cnt_before", 32'(cnt), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mr_pulse", 32'(out_pulse), 32'd0);
    chk("mr_cnt",   32'(cnt),       32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_tally", 32'(tally),     32'd0);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("mr_def_pulse_k%0d", k), 32'(out_pulse), 32'(k == 5));
    end
    stop = 1'b1; step(); stop = 1'b0;

    // period 0 clamps to 1: pulse every cycle, cnt stays 0
    load = 1'b1; period = 8'd0; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("p1_pulse_k%0d", k), 32'(out_pulse), 32'd1);
      chk($sformatf("p1_cnt_k%0d", k),   32'(cnt),       32'd0);
      chk($sformatf("p1_tally_k%0d", k), 32'(tally),     32'(k));
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("p1_stop_pulse", 32'(out_pulse), 32'd0);
    chk("p1_stop_busy",  32'(busy),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
